// File: rtl/shift_pipe.sv
// Two-stage pipelined 16-bit shift/rotate unit: every op is normalised to a left-rotate count,
// rotated through a 1/2/4/8 log shifter and masked. Optional zero flag: SHIFT_ZERO_FLAG_EN.
module shift_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [3:0]  in_cnt,
    input  logic [1:0]  in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
`ifdef SHIFT_ZERO_FLAG_EN
    ,
    output logic        out_zero
`endif
);

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    function automatic logic [15:0] rotl_log(input logic [15:0] d, input logic [3:0] n);
        logic [15:0] l1;
        logic [15:0] l2;
        logic [15:0] l4;
        logic [15:0] l8;
        l1 = n[0] ? {d[14:0],  d[15]}     : d;
        l2 = n[1] ? {l1[13:0], l1[15:14]} : l1;
        l4 = n[2] ? {l2[11:0], l2[15:12]} : l2;
        l8 = n[3] ? {l4[7:0],  l4[15:8]}  : l4;
        return l8;
    endfunction

    function automatic logic [15:0] shift_mask(input logic [1:0] op, input logic [3:0] cnt);
        logic [15:0] m;
        case (op)
            OP_SLL:  m = 16'hFFFF << cnt;
            OP_SRL:  m = 16'hFFFF >> cnt;
            OP_ROL:  m = 16'hFFFF;
            OP_ROR:  m = 16'hFFFF;
            default: m = 16'hFFFF;
        endcase
        return m;
    endfunction

    logic        a_valid_r;
    logic [15:0] a_data_r;
    logic [3:0]  a_rcnt_r;
    logic [3:0]  a_cnt_r;
    logic [1:0]  a_op_r;

    logic        advance_s;
    logic        a_load_s;
    logic        accept_s;
    logic [3:0]  rcnt_s;
    logic [15:0] result_s;

    // Handshake: stage B drains when empty or taken; stage A refills when it is empty or moving on.
    always_comb begin
        advance_s = !out_valid || out_ready;
        a_load_s  = advance_s || !a_valid_r;
        if (rst) begin
            in_ready = 1'b0;
        end else begin
            in_ready = a_load_s;
        end
        accept_s = in_valid && in_ready;
    end

    // Right-hand ops become a left rotate by (16 - cnt) mod 16; 4-bit wrap keeps cnt 0 at 0.
    always_comb begin
        if (in_op[1]) begin
            rcnt_s = 4'd0 - in_cnt;
        end else begin
            rcnt_s = in_cnt;
        end
    end

    // Stage B datapath: rotate then clear the bits a logical shift would have filled with zeros.
    always_comb begin
        result_s = rotl_log(a_data_r, a_rcnt_r) & shift_mask(a_op_r, a_cnt_r);
    end

    // Stage A register.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_r <= 1'b0;
            a_data_r  <= 16'h0000;
            a_rcnt_r  <= 4'd0;
            a_cnt_r   <= 4'd0;
            a_op_r    <= 2'b00;
        end else if (a_load_s) begin
            a_valid_r <= accept_s;
            if (accept_s) begin
                a_data_r <= in_data;
                a_rcnt_r <= rcnt_s;
                a_cnt_r  <= in_cnt;
                a_op_r   <= in_op;
            end
        end
    end

    // Stage B / output register; data only moves when a real result arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
        end else if (advance_s) begin
            out_valid <= a_valid_r;
            if (a_valid_r) begin
                out_data <= result_s;
            end
        end
    end

`ifdef SHIFT_ZERO_FLAG_EN
    // Zero flag travels with out_data and stalls with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_zero <= 1'b1;
        end else if (advance_s && a_valid_r) begin
            out_zero <= (result_s == 16'h0000);
        end
    end
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed vectors, sweep, backpressure, reset, random traffic.
module tb_shift_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic [3:0]  in_cnt = 4'd0;
    logic [1:0]  in_op = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
`ifdef SHIFT_ZERO_FLAG_EN
    logic        out_zero;
    logic        s_oz;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic        s_acc, s_dlv, s_ir, s_ov;
    logic [15:0] s_od;
    logic [15:0] expq[$];

    shift_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_cnt(in_cnt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef SHIFT_ZERO_FLAG_EN
        , .out_zero(out_zero)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_op(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op);
        logic [31:0] x;
        logic [31:0] r;
        int n;
        x = {16'h0000, d};
        n = c;
        case (op)
            2'b00:   r = (x << n) | (x >> (16 - n));
            2'b01:   r = x << n;
            2'b10:   r = (x >> n) | (x << (16 - n));
            default: r = x >> n;
        endcase
        return r[15:0];
    endfunction

    // Drive one cycle at the falling edge, sample the settled outputs, then let the rising edge happen.
    task automatic step(input logic r, input logic v, input logic [15:0] d, input logic [3:0] c,
                        input logic [1:0] op, input logic ordy);
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; in_cnt = c; in_op = op; out_ready = ordy;
        #1;
        s_ir  = in_ready;
        s_ov  = out_valid;
        s_od  = out_data;
        s_acc = v && in_ready;
        s_dlv = out_valid && ordy;
`ifdef SHIFT_ZERO_FLAG_EN
        s_oz  = out_zero;
`endif
        @(posedge clk);
    endtask

    task automatic test_reset;
        step(1'b1, 1'b1, 16'hFFFF, 4'd3, 2'b01, 1'b1);
        step(1'b1, 1'b1, 16'hFFFF, 4'd3, 2'b01, 1'b1);
        step(1'b1, 1'b0, 16'h0000, 4'd0, 2'b00, 1'b1);
        n_vec++;
        if (s_ir !== 1'b0 || s_ov !== 1'b0 || s_od !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h, want 0 0 0000", s_ir, s_ov, s_od);
        end
`ifdef SHIFT_ZERO_FLAG_EN
        n_vec++;
        if (s_oz !== 1'b1) begin
            n_err++;
            $display("FAIL reset_zero: out_zero=%b want 1", s_oz);
        end
`endif
        step(1'b0, 1'b0, 16'h0000, 4'd0, 2'b00, 1'b1);
        n_vec++;
        if (s_ir !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: in_ready=%b want 1", s_ir);
        end
    endtask

    task automatic test_directed;
        logic [15:0] dv [7] = '{16'h8001, 16'h0001, 16'h1234, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h8000};
        logic [3:0]  cv [7] = '{4'd1, 4'd1, 4'd4, 4'd4, 4'd15, 4'd0, 4'd1};
        logic [1:0]  ov [7] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b11, 2'b11, 2'b01};
        logic [15:0] ev [7] = '{16'h0003, 16'h8000, 16'h2341, 16'hFFF0, 16'h0001, 16'hFFFF, 16'h0000};
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, dv[i], cv[i], ov[i], 1'b1);
            n_vec++;
            if (s_acc !== 1'b1) begin
                n_err++;
                $display("FAIL directed_accept[%0d]: accepted=%b want 1", i, s_acc);
            end
            step(1'b0, 1'b0, 16'h0000, 4'd0, 2'b00, 1'b1);
            n_vec++;
            if (s_ov !== 1'b0) begin
                n_err++;
                $display("FAIL directed_early[%0d]: out_valid=%b one edge after accept, want 0", i, s_ov);
            end
            step(1'b0, 1'b0, 16'h0000, 4'd0, 2'b00, 1'b1);
            n_vec++;
            if (s_ov !== 1'b1 || s_od !== ev[i]) begin
                n_err++;
                $display("FAIL directed[%0d]: out_valid=%b out_data=%h, want 1 %h", i, s_ov, s_od, ev[i]);
            end
`ifdef SHIFT_ZERO_FLAG_EN
            n_vec++;
            if (s_oz !== (ev[i] == 16'h0000)) begin
                n_err++;
                $display("FAIL directed_zero[%0d]: out_zero=%b want %b", i, s_oz, ev[i] == 16'h0000);
            end
`endif
        end
    endtask

    task automatic test_sweep;
        int sent = 0;
        int got = 0;
        bit flowing = 1'b0;
        for (int cyc = 0; cyc < 100 && got < 64; cyc++) begin
            if (sent < 64) begin
                step(1'b0, 1'b1, 16'hA5C3, sent[3:0], sent[5:4], 1'b1);
            end else begin
                step(1'b0, 1'b0, 16'h0000, 4'd0, 2'b00, 1'b1);
            end
            if (sent < 64) begin
                n_vec++;
                if (!s_acc) begin
                    n_err++;
                    $display("FAIL sweep_accept: op %0d not accepted", sent);
                end else begin
                    expq.push_back(ref_op(16'hA5C3, sent[3:0], sent[5:4]));
                    sent++;
                end
            end
            if (flowing) begin
                n_vec++;
                if (!s_dlv) begin
                    n_err++;
                    $display("FAIL sweep_gap: no result at index %0d", got);
                end
            end
            if (s_dlv) begin
                flowing = 1'b1;
                n_vec++;
                if (expq.size() == 0) begin
                    n_err++;
                    $display("FAIL sweep_extra: got %h with nothing outstanding", s_od);
                end else if (s_od !== expq[0]) begin
                    n_err++;
                    $display("FAIL sweep_data[%0d]: got %h want %h", got, s_od, expq[0]);
                    void'(expq.pop_front());
                end else begin
                    void'(expq.pop_front());
                end
                got++;
            end
        end
        n_vec++;
        if (got != 64) begin
            n_err++;
            $display("FAIL sweep_count: got %0d results want 64", got);
        end
        expq.delete();
    endtask

    task automatic test_backpressure;
        logic [15:0] e1, e2, e3;
        e1 = ref_op(16'h1357, 4'd3, 2'b00);
        e2 = ref_op(16'hF00F, 4'd5, 2'b11);
        e3 = ref_op(16'h0FF0, 4'd9, 2'b01);
        step(1'b0, 1'b1, 16'h1357, 4'd3, 2'b00, 1'b0);
        n_vec++;
        if (!s_acc) begin n_err++; $display("FAIL bp_acc1: accepted=%b want 1", s_acc); end
        step(1'b0, 1'b1, 16'hF00F, 4'd5, 2'b11, 1'b0);
        n_vec++;
        if (!s_acc) begin n_err++; $display("FAIL bp_acc2: accepted=%b want 1", s_acc); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 16'h0FF0, 4'd9, 2'b01, 1'b0);
            n_vec++;
            if (s_ir !== 1'b0 || s_ov !== 1'b1 || s_od !== e1) begin
                n_err++;
                $display("FAIL bp_stall[%0d]: in_ready=%b out_valid=%b out_data=%h, want 0 1 %h", i, s_ir, s_ov, s_od, e1);
            end
        end
        step(1'b0, 1'b1, 16'h0FF0, 4'd9, 2'b01, 1'b1);
        n_vec++;
        if (!s_acc || !s_dlv || s_od !== e1) begin
            n_err++;
            $display("FAIL bp_release: acc=%b dlv=%b out_data=%h, want 1 1 %h", s_acc, s_dlv, s_od, e1);
        end
        step(1'b0, 1'b0, 16'h0000, 4'd0, 2'b00, 1'b1);
        n_vec++;
        if (!s_dlv || s_od !== e2) begin
            n_err++;
            $display("FAIL bp_second: dlv=%b out_data=%h, want 1 %h", s_dlv, s_od, e2);
        end
        step(1'b0, 1'b0, 16'h0000, 4'd0, 2'b00, 1'b1);
        n_vec++;
        if (!s_dlv || s_od !== e3) begin
            n_err++;
            $display("FAIL bp_third: dlv=%b out_data=%h, want 1 %h", s_dlv, s_od, e3);
        end
        step(1'b0, 1'b0, 16'h0000, 4'd0, 2'b00, 1'b1);
        n_vec++;
        if (s_ov !== 1'b0 || s_od !== e3) begin
            n_err++;
            $display("FAIL bp_idle_hold: out_valid=%b out_data=%h, want 0 %h", s_ov, s_od, e3);
        end
    endtask

    task automatic test_reset_mid;
        step(1'b0, 1'b1, 16'hBEEF, 4'd7, 2'b10, 1'b0);
        step(1'b0, 1'b1, 16'hCAFE, 4'd2, 2'b01, 1'b0);
        step(1'b1, 1'b1, 16'h1111, 4'd1, 2'b00, 1'b0);
        n_vec++;
        if (s_ov !== 1'b1 || s_ir !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_full: out_valid=%b in_ready=%b, want 1 0", s_ov, s_ir);
        end
        step(1'b1, 1'b0, 16'h0000, 4'd0, 2'b00, 1'b0);
        n_vec++;
        if (s_ov !== 1'b0 || s_od !== 16'h0000 || s_ir !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_reset: out_valid=%b out_data=%h in_ready=%b, want 0 0000 0", s_ov, s_od, s_ir);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 16'h0000, 4'd0, 2'b00, 1'b1);
            n_vec++;
            if (s_ir !== 1'b1 || s_ov !== 1'b0) begin
                n_err++;
                $display("FAIL rmid_stale[%0d]: in_ready=%b out_valid=%b, want 1 0", i, s_ir, s_ov);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] d;
        logic [3:0]  c;
        logic [1:0]  op;
        logic        v, r;
        expq.delete();
        for (int i = 0; i < 400; i++) begin
            d  = 16'($urandom);
            c  = 4'($urandom_range(0, 15));
            op = 2'($urandom_range(0, 3));
            v  = ($urandom_range(0, 3) != 0);
            r  = (i >= 360) || ($urandom_range(0, 2) != 0);
            step(1'b0, v, d, c, op, r);
            if (s_dlv) begin
                n_vec++;
                if (expq.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_extra: got %h with nothing outstanding", s_od);
                end else if (s_od !== expq[0]) begin
                    n_err++;
                    $display("FAIL rand_data: got %h want %h", s_od, expq[0]);
                    void'(expq.pop_front());
                end else begin
                    void'(expq.pop_front());
                end
            end
            if (s_acc && i < 360) expq.push_back(ref_op(d, c, op));
            else if (s_acc) expq.push_back(ref_op(d, c, op));
        end
        for (int i = 0; i < 20 && expq.size() != 0; i++) begin
            step(1'b0, 1'b0, 16'h0000, 4'd0, 2'b00, 1'b1);
            if (s_dlv) begin
                n_vec++;
                if (s_od !== expq[0]) begin
                    n_err++;
                    $display("FAIL rand_drain: got %h want %h", s_od, expq[0]);
                end
                void'(expq.pop_front());
            end
        end
        n_vec++;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL rand_lost: %0d results never delivered, want 0", expq.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sweep();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Two-stage pipelined 16-bit shift/rotate unit for the execute stage. It accepts an operand, a 4-bit count and a shift opcode over a valid/ready handshake, and normalises every operation to a left-rotate count. It then performs a 4-level logarithmic rotate (1/2/4/8), applies a logical-shift mask, and presents a registered result downstream. Latency is fixed at two cycles, with full throughput and backpressure support.

## Interface
- No parameters; data width fixed at 16, count width fixed at 4.
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  block can accept; transfer when in_valid && in_ready at a rising edge.
- in_data  input  16  operand.
- in_cnt  input  4  shift/rotate amount, 0–15.
- in_op  input  2  00 ROL, 01 SLL, 10 ROR, 11 SRL.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  downstream accepts; transfer when out_valid && out_ready at a rising edge.
- out_data  output  16  result.
- out_zero  output  1  result == 0 (only when SHIFT_ZERO_FLAG_EN is defined).

## Operation
- **Stage A register:** a_valid, a_data, a_rcnt[3:0], a_op.
  - On accept, a_rcnt = in_cnt for ROL/SLL.
  - On accept, a_rcnt = (16 − in_cnt) mod 16 for ROR/SRL. Computed before registering; 4-bit wrap, so cnt 0 → 0.
- **Stage B logic and register:**
  - rot = a_data rotated left by a_rcnt, built from 4 cascaded mux levels selected by a_rcnt[0..3].
  - ROL/ROR: result = rot.
  - SLL: result = rot & (16'hFFFF << in_cnt_orig).
  - SRL: result = rot & (16'hFFFF >> in_cnt_orig).
  - Stage A also keeps a_cnt (the original count) for the mask.
  - Result is registered into out_data/out_valid.
- **Flow control:**
  - advance = !out_valid || out_ready.
  - in_ready = !rst && (!a_valid || advance).
  - When advance: out_valid ← a_valid, and out_data ← result if a_valid.
  - When advance or !a_valid: stage A loads the input; a_valid ← in_valid && in_ready.
  - When !advance: both stages hold all contents.
- **Data rules:**
  - out_data is unchanged while out_valid && !out_ready.
  - No operation is dropped or duplicated.
  - When out_valid = 0, out_data holds its last value.
- **Reset:**
  - a_valid = 0, out_valid = 0, out_data = 16'h0000, out_zero = 1, in_ready = 0 while rst is high.
  - In-flight operations are discarded, including a reset mid-stall.
  - in_ready = 1 on the first cycle after rst deasserts.
- **Boundaries:**
  - cnt = 0: identity for all ops.
  - SLL/SRL with cnt = 15 leave one surviving bit.
  - Simultaneous accept on input and output while both stages are full: the pipeline shifts by one and stays full.
  - Opcode changes between consecutive ops have no interaction; each op is self-contained.

## Timing
- Input accepted at edge N → a_valid from N. Result registered at edge N+1 (if advance) → out_valid visible in the cycle after N+1.
- Minimum latency is 2 edges; throughput is 1 op/cycle with out_ready held high.
- With out_ready low, at most 2 ops are buffered (stage A and stage B). in_ready falls combinationally in the same cycle both are full.
- in_ready depends combinationally on out_ready. out_valid and out_data are pure register outputs.
- Critical path: a_rcnt → 4 mux levels → mask AND → out register.

## Configuration
- SHIFT_ZERO_FLAG_EN defined:
  - out_zero port exists, registered alongside out_data, equal to (result == 16'h0000).
  - Reset value is 1.
  - Held with out_data during stalls.
- SHIFT_ZERO_FLAG_EN undefined:
  - No out_zero port and no zero-detect logic.
  - All other behaviour is identical.

## Test plan
- **Rotates:** ROL 16'h8001 cnt 1 → 16'h0003; ROR 16'h0001 cnt 1 → 16'h8000; ROL 16'h1234 cnt 4 → 16'h2341. Each with out_valid exactly 2 edges after accept.
- **Logical shifts:** SLL 16'hFFFF cnt 4 → 16'hFFF0; SRL 16'h8000 cnt 15 → 16'h0001; SRL 16'hFFFF cnt 0 → 16'hFFFF. With SHIFT_ZERO_FLAG_EN, SLL 16'h8000 cnt 1 → out_data 0, out_zero 1.
- **Exhaustive sweep:** all 4 ops × cnt 0–15 on 16'hA5C3, back-to-back with out_ready high. Results match the software model, one per cycle, in order.
- **Backpressure:**
  - Hold out_ready low and send 3 ops: in_ready drops after the 2nd accept; the 3rd is held by upstream.
  - out_data stays stable for the stall.
  - Releasing out_ready yields all 3 results in order, with no gaps once flowing.
- **Reset mid-operation:**
  - Assert rst with both stages full and out_ready low → next cycle out_valid 0, out_data 16'h0000, in_ready 0.
  - After deassert, in_ready 1 and no stale result appears.
